// File: rtl/countdown_sched_pkg.sv
// Shared types and default widths for the countdown scheduler and its arbiter.
package countdown_sched_pkg;

  localparam int unsigned DEF_N_REQ = 4;
  localparam int unsigned DEF_CW    = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter_n.sv
// Combinational round-robin pick: first set request at or above i_ptr, wrapping
// around to the lowest index when nothing at or above the pointer is requesting.
module rr_arbiter_n #(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDW-1:0]   i_ptr,
  output logic [IDW-1:0]   o_winner,
  output logic             o_valid
);

  logic           w_found;
  logic [IDW-1:0] w_winner;

  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    // Upper pass covers [ptr, N_REQ); the wrap pass only fires if it found nothing.
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!w_found && i_req[i] && (i >= 32'(i_ptr))) begin
        w_found  = 1'b1;
        w_winner = IDW'(i);
      end
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!w_found && i_req[i]) begin
        w_found  = 1'b1;
        w_winner = IDW'(i);
      end
    end
  end

  assign o_winner = w_winner;
  assign o_valid  = w_found;

endmodule

// File: rtl/countdown_scheduler.sv
// One shared countdown timer, handed round-robin to N_REQ requesters; each
// owner gets its len ticks counted down and a one-cycle done pulse at the end.
module countdown_scheduler
  import countdown_sched_pkg::*;
#(
  parameter  int unsigned N_REQ = DEF_N_REQ,
  parameter  int unsigned CW    = DEF_CW,
  localparam int unsigned IDW   = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                tick,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*CW-1:0] len,
  output logic [N_REQ-1:0]    grant,
  output logic                busy,
  output logic [N_REQ-1:0]    done,
  output logic [CW-1:0]       remaining,
  output logic [IDW-1:0]      active_id
);

  sched_state_t   r_state, w_state_nxt;
  logic [CW-1:0]  r_remaining, w_remaining_nxt;
  logic [IDW-1:0] r_active_id, w_active_id_nxt;
  logic [IDW-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic [N_REQ-1:0] r_done, w_done_nxt;
  logic           r_busy, w_busy_nxt;

  logic [CW-1:0]    w_len_arr [N_REQ];
  logic [CW-1:0]    w_owner_len;
  logic [N_REQ-1:0] w_owner_onehot;
  logic             w_owner_req;
  logic [IDW-1:0]   w_ptr_after_owner;
  logic [IDW-1:0]   w_arb_winner;
  logic             w_arb_valid;

  rr_arbiter_n #(
    .N_REQ (N_REQ)
  ) u_arb (
    .i_req    (req),
    .i_ptr    (r_rr_ptr),
    .o_winner (w_arb_winner),
    .o_valid  (w_arb_valid)
  );

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      w_len_arr[i] = len[i*CW +: CW];
    end
  end

  assign w_owner_len       = w_len_arr[r_active_id];
  assign w_owner_onehot    = N_REQ'(1) << r_active_id;
  assign w_owner_req       = req[r_active_id];
  assign w_ptr_after_owner = (r_active_id == IDW'(N_REQ - 1)) ? '0 : r_active_id + 1'b1;

  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_active_id_nxt = r_active_id;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_done_nxt      = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_arb_valid) begin
          w_state_nxt     = ST_LOAD;
          w_active_id_nxt = w_arb_winner;
        end
      end
      ST_LOAD: begin
        if (!w_owner_req) begin
          w_state_nxt     = ST_IDLE;
          w_rr_ptr_nxt    = w_ptr_after_owner;
          w_remaining_nxt = '0;
          w_active_id_nxt = '0;
        end else begin
          w_remaining_nxt = w_owner_len;
          if (w_owner_len != '0) begin
            w_state_nxt = ST_COUNT;
          end else begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = w_owner_onehot;
          end
        end
      end
      ST_COUNT: begin
        // Abort wins over a coincident final tick: no done for a dropped request.
        if (!w_owner_req) begin
          w_state_nxt     = ST_IDLE;
          w_rr_ptr_nxt    = w_ptr_after_owner;
          w_remaining_nxt = '0;
          w_active_id_nxt = '0;
        end else if (tick && (r_remaining != '0)) begin
          w_remaining_nxt = r_remaining - 1'b1;
          if (r_remaining == CW'(1)) begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = w_owner_onehot;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt     = ST_IDLE;
        w_rr_ptr_nxt    = w_ptr_after_owner;
        w_remaining_nxt = '0;
        w_active_id_nxt = '0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_active_id <= '0;
      r_rr_ptr    <= '0;
      r_done      <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_active_id <= w_active_id_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_done      <= w_done_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign grant     = (r_state != ST_IDLE) ? w_owner_onehot : '0;
  assign busy      = r_busy;
  assign done      = r_done;
  assign remaining = r_remaining;
  assign active_id = r_active_id;

endmodule

// File: tb/tb_countdown_scheduler.sv
// Directed bench for countdown_scheduler: expected done pulses are queued as
// requests are issued and retired by a negedge monitor when done fires.
module tb_countdown_scheduler;

  logic        clk = 1'b0;
  logic        resetn;
  logic        tick;
  logic [3:0]  req;
  logic [15:0] len;
  logic [3:0]  grant;
  logic        busy;
  logic [3:0]  done;
  logic [3:0]  remaining;
  logic [1:0]  active_id;

  int checks = 0;
  int errors = 0;
  logic [3:0] sb [$];

  countdown_scheduler #(
    .N_REQ (4),
    .CW    (4)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .tick      (tick),
    .req       (req),
    .len       (len),
    .grant     (grant),
    .busy      (busy),
    .done      (done),
    .remaining (remaining),
    .active_id (active_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [3:0] exp_done;
    if (done !== 4'b0000) begin
      exp_done = (sb.size() > 0) ? sb.pop_front() : 4'b0000;
      checks++;
      assert (done === exp_done) else begin
        errors++;
        $error("FAIL sb_done observed=%b expected=%b", done, exp_done);
      end
    end
  end

  initial begin
    // Reset then single request on requester 2, len 3, sparse ticks
    resetn = 1'b0; tick = 1'b0; req = 4'b0100; len = 16'h0300;
    cyc(2);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_remaining", remaining, 0);
    chk("rst_active_id", active_id, 0);
    resetn = 1'b1;
    sb.push_back(4'b0100);
    cyc();
    chk("t1_grant", grant, 4'b0100);
    chk("t1_active_id", active_id, 2);
    chk("t1_busy", busy, 1);
    cyc();
    chk("t1_loaded", remaining, 3);
    cyc(3);
    chk("t1_hold", remaining, 3);
    tick = 1'b1; cyc(); tick = 1'b0;
    chk("t1_rem2", remaining, 2);
    cyc(3);
    tick = 1'b1; cyc(); tick = 1'b0;
    chk("t1_rem1", remaining, 1);
    chk("t1_no_done_yet", done, 0);
    cyc(3);
    tick = 1'b1; cyc(); tick = 1'b0;
    chk("t1_rem0", remaining, 0);
    chk("t1_done", done, 4'b0100);
    chk("t1_grant_in_done", grant, 4'b0100);
    req = 4'b0000;
    cyc();
    chk("t1_done_one_cycle", done, 0);
    chk("t1_busy_off", busy, 0);
    chk("t1_grant_off", grant, 0);

    // Round-robin fairness from rr_ptr=0, all len 1, tick every cycle
    resetn = 1'b0; cyc(); resetn = 1'b1;
    len = 16'h1111; tick = 1'b1; req = 4'b1111;
    sb.push_back(4'b0001); sb.push_back(4'b0010); sb.push_back(4'b0100);
    sb.push_back(4'b1000); sb.push_back(4'b0001);
    cyc();
    chk("rr_first_owner", active_id, 0);
    cyc(4);
    chk("rr_second_owner", active_id, 1);
    cyc(15);
    req = 4'b0000; tick = 1'b0;
    cyc(2);
    chk("rr_all_served", sb.size(), 0);
    chk("rr_idle", busy, 0);

    // Zero length on requester 0: LOAD goes straight to DONE, no tick
    len = 16'h0000; req = 4'b0001;
    sb.push_back(4'b0001);
    cyc();
    chk("z_grant", grant, 4'b0001);
    chk("z_no_done_in_load", done, 0);
    cyc();
    chk("z_done", done, 4'b0001);
    chk("z_remaining", remaining, 0);
    req = 4'b0000;
    cyc();
    chk("z_idle", busy, 0);

    // Abort requester 1 after two ticks, then rr_ptr=2 must wrap to 0
    len = 16'h0050; req = 4'b0010;
    cyc();
    chk("ab_grant", grant, 4'b0010);
    cyc();
    chk("ab_loaded", remaining, 5);
    tick = 1'b1; cyc(2); tick = 1'b0;
    chk("ab_rem3", remaining, 3);
    req = 4'b0000;
    cyc();
    chk("ab_idle_busy", busy, 0);
    chk("ab_idle_grant", grant, 0);
    chk("ab_idle_rem", remaining, 0);
    req = 4'b0011;
    sb.push_back(4'b0001);
    cyc();
    chk("ab_wrap_winner", active_id, 0);
    chk("ab_wrap_grant", grant, 4'b0001);
    cyc();
    chk("ab_wrap_done", done, 4'b0001);
    req = 4'b0000;
    cyc();

    // Async reset mid-count on requester 3 with remaining 7
    len = 16'h7000; req = 4'b1000;
    cyc(2);
    chk("ar_count", remaining, 7);
    chk("ar_owner", active_id, 3);
    #3 resetn = 1'b0;
    #1;
    chk("ar_grant_now", grant, 0);
    chk("ar_busy_now", busy, 0);
    chk("ar_rem_now", remaining, 0);
    chk("ar_id_now", active_id, 0);
    req = 4'b1001;
    cyc();
    resetn = 1'b1;
    sb.push_back(4'b0001);
    cyc();
    chk("ar_restart_ptr0", active_id, 0);
    cyc();
    chk("ar_restart_done", done, 4'b0001);
    req = 4'b0000;
    cyc();

    // Ticks in IDLE/LOAD are ignored; exactly two COUNT ticks needed
    len = 16'h0200; req = 4'b0100; tick = 1'b1;
    sb.push_back(4'b0100);
    cyc();
    chk("tg_load_rem", remaining, 0);
    cyc();
    chk("tg_count_rem", remaining, 2);
    tick = 1'b0;
    cyc();
    tick = 1'b1; cyc(); tick = 1'b0;
    chk("tg_rem1", remaining, 1);
    chk("tg_not_done", done, 0);
    cyc(2);
    tick = 1'b1; cyc(); tick = 1'b0;
    chk("tg_done", done, 4'b0100);
    req = 4'b0000;
    cyc(3);
    chk("final_sb_empty", sb.size(), 0);
    chk("final_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
